// File: rtl/onchip_ram_dp_param_if.sv
// -----------------------------------------------------------------------------
// onchip_ram_dp_param_if
//   Avalon-MM slave bundle for one port of onchip_ram_dp_param.
//
//   address        word address (ADDR_WIDTH)
//   chipselect     port select
//   read / write   transfer requests
//   byteenable     byte-lane enables (DATA_WIDTH/8)
//   writedata      write data
//   readdata       read data, qualified by readdatavalid
//   readdatavalid  one-cycle strobe per accepted read
//   waitrequest    stall; a request is taken only when low
//
//   master: drives requests (interconnect / bench)
//   slave : the RAM port
// -----------------------------------------------------------------------------
interface onchip_ram_dp_param_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic [ADDR_WIDTH-1:0]   address;
  logic                    chipselect;
  logic                    read;
  logic                    write;
  logic [DATA_WIDTH/8-1:0] byteenable;
  logic [DATA_WIDTH-1:0]   writedata;
  logic [DATA_WIDTH-1:0]   readdata;
  logic                    readdatavalid;
  logic                    waitrequest;

  modport master (
    output address, chipselect, read, write, byteenable, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, chipselect, read, write, byteenable, writedata,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/onchip_ram_dp_param.sv
// -----------------------------------------------------------------------------
// onchip_ram_dp_param
//   Parametrised true-dual-port on-chip RAM with two Avalon-MM slave ports.
//   Byte-lane writes, pipelined reads (latency 1 or 2) with readdatavalid,
//   a fixed write-collision merge rule (s1 owns the lanes it enables) and an
//   optional zero-fill sequencer that runs after reset release.
//
//   clk    in   single clock for both ports
//   reset  in   synchronous, active-high
//   clken  in   global clock enable; 0 freezes FSM, read pipe and writes
//   s1/s2  slave modport of onchip_ram_dp_param_if
//   busy   out  high while in reset or while the clear sequencer runs
// -----------------------------------------------------------------------------
module onchip_ram_dp_param #(
  parameter int    DATA_WIDTH     = 32,
  parameter int    DEPTH          = 1024,
  parameter int    ADDR_WIDTH     = 10,
  parameter int    READ_LATENCY   = 1,
  parameter int    CLEAR_ON_RESET = 0,
  parameter string INIT_FILE      = "onchip_ram_dp_param.hex"
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clken,
  onchip_ram_dp_param_if.slave  s1,
  onchip_ram_dp_param_if.slave  s2,
  output logic                  busy
);

  localparam int                    NB        = DATA_WIDTH / 8;
  localparam logic [31:0]           DEPTH_U   = 32'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  // Power-up contents are attached to the array by the device's
  // memory-initialisation flow under the name INIT_FILE; the clear
  // sequencer overrides them with zeros when enabled.
  if (INIT_FILE == "") begin : g_no_init_file
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  // State the block lands in on the first cycle after reset drops.
  localparam state_t ENTRY_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

  state_t                state_reg;
  state_t                state_next;
  state_t                state_cur;
  logic [ADDR_WIDTH-1:0] clr_cnt_reg;
  logic [ADDR_WIDTH-1:0] clr_cnt_next;
  logic                  clr_we;

  // The register is loaded with the entry state while reset is high, so the
  // first reset-free cycle is already CLEAR (or RUN); RST is simply "reset is
  // high right now". This keeps CLEAR at exactly DEPTH enabled cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ENTRY_STATE;
      clr_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clr_cnt_reg <= clr_cnt_next;
    end
  end

  always_comb begin
    state_cur    = reset ? ST_RST : state_reg;
    state_next   = state_cur;
    clr_cnt_next = clr_cnt_reg;
    clr_we       = 1'b0;
    case (state_cur)
      ST_RST: begin
        state_next   = ENTRY_STATE;
        clr_cnt_next = '0;
      end
      ST_CLEAR: begin
        if (clken) begin
          clr_we = 1'b1;
          if (clr_cnt_reg == LAST_ADDR) begin
            state_next   = ST_RUN;
            clr_cnt_next = '0;
          end else begin
            clr_cnt_next = clr_cnt_reg + ADDR_WIDTH'(1);
          end
        end
      end
      ST_RUN: begin
        state_next = ST_RUN;
      end
      default: begin
        state_next   = ENTRY_STATE;
        clr_cnt_next = '0;
      end
    endcase
  end

  logic waitrequest;
  logic run_go;

  assign busy        = (state_cur != ST_RUN);
  assign waitrequest = busy | ~clken;
  assign run_go      = ~waitrequest;

  // ---------------------------------------------------------------------------
  // Port unpacking: index 0 = s1, index 1 = s2
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] p_addr   [2];
  logic [1:0]            p_cs;
  logic [1:0]            p_rd;
  logic [1:0]            p_wr;
  logic [NB-1:0]         p_be     [2];
  logic [DATA_WIDTH-1:0] p_wd     [2];
  logic [DATA_WIDTH-1:0] p_rdata  [2];
  logic [1:0]            p_rvalid;

  assign p_addr[0] = s1.address;
  assign p_cs[0]   = s1.chipselect;
  assign p_rd[0]   = s1.read;
  assign p_wr[0]   = s1.write;
  assign p_be[0]   = s1.byteenable;
  assign p_wd[0]   = s1.writedata;

  assign p_addr[1] = s2.address;
  assign p_cs[1]   = s2.chipselect;
  assign p_rd[1]   = s2.read;
  assign p_wr[1]   = s2.write;
  assign p_be[1]   = s2.byteenable;
  assign p_wd[1]   = s2.writedata;

  assign s1.readdata      = p_rdata[0];
  assign s1.readdatavalid = p_rvalid[0];
  assign s1.waitrequest   = waitrequest;

  assign s2.readdata      = p_rdata[1];
  assign s2.readdatavalid = p_rvalid[1];
  assign s2.waitrequest   = waitrequest;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [1:0]    wr_acc;
  logic [1:0]    rd_acc;
  logic [1:0]    in_range;
  logic [NB-1:0] lane_we [2];
  logic          same_addr;
  logic [NB-1:0] lane_we_s2;

  // On a same-address collision s2 loses every lane that s1 also enables.
  assign same_addr  = (p_addr[0] == p_addr[1]);
  assign lane_we_s2 = lane_we[1] & ~(same_addr ? lane_we[0] : {NB{1'b0}});

  // Clear writes only happen while both ports are stalled, so they never
  // overlap a port write.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_cnt_reg] <= '0;
    end
    for (int b = 0; b < NB; b++) begin
      if (lane_we_s2[b]) begin
        mem[p_addr[1]][b*8 +: 8] <= p_wd[1][b*8 +: 8];
      end
      if (lane_we[0][b]) begin
        mem[p_addr[0]][b*8 +: 8] <= p_wd[0][b*8 +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-port accept logic and read pipeline
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic                  v1_reg;
    logic                  oor1_reg;
    logic [DATA_WIDTH-1:0] raw1_reg;
    logic [DATA_WIDTH-1:0] stage1_data;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;

    // A simultaneous read+write is treated as a write only.
    assign wr_acc[gi]   = p_cs[gi] & p_wr[gi] & run_go;
    assign rd_acc[gi]   = p_cs[gi] & p_rd[gi] & ~p_wr[gi] & run_go;
    assign in_range[gi] = (32'(p_addr[gi]) < DEPTH_U);
    assign lane_we[gi]  = {NB{wr_acc[gi] & in_range[gi]}} & p_be[gi];

    // Stage 1: registered array read. Reading before this edge's write commits
    // gives old-data semantics for read-during-write. Data only reloads on an
    // accepted read, so readdata holds between valids.
    always_ff @(posedge clk) begin
      if (reset) begin
        v1_reg   <= 1'b0;
        oor1_reg <= 1'b0;
        raw1_reg <= '0;
      end else if (clken) begin
        v1_reg <= rd_acc[gi];
        if (rd_acc[gi]) begin
          raw1_reg <= mem[p_addr[gi]];
          oor1_reg <= ~in_range[gi];
        end
      end
    end

    // Out-of-range reads complete normally but return zero.
    assign stage1_data = oor1_reg ? '0 : raw1_reg;

    if (READ_LATENCY >= 2) begin : g_lat2
      logic                  v2_reg;
      logic [DATA_WIDTH-1:0] d2_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          v2_reg <= 1'b0;
          d2_reg <= '0;
        end else if (clken) begin
          v2_reg <= v1_reg;
          if (v1_reg) begin
            d2_reg <= stage1_data;
          end
        end
      end

      assign out_valid = v2_reg;
      assign out_data  = d2_reg;
    end else begin : g_lat1
      assign out_valid = v1_reg;
      assign out_data  = stage1_data;
    end

    // While clken is low the pending word stays in the pipe but is not
    // presented, so it is seen for exactly one enabled cycle.
    assign p_rvalid[gi] = out_valid & clken & ~reset;
    assign p_rdata[gi]  = reset ? '0 : out_data;
  end

endmodule

// File: tb/tb_onchip_ram_dp_param.sv
// -----------------------------------------------------------------------------
// tb_onchip_ram_dp_param
//   Two DUT instances on one clock:
//     u_a : DEPTH=16, READ_LATENCY=1, CLEAR_ON_RESET=1  (bus[0]=s1, bus[1]=s2)
//     u_b : DEPTH=12, READ_LATENCY=2, CLEAR_ON_RESET=0  (bus[2]=s1, bus[3]=s2)
//   Inputs change 1 ns after the rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_onchip_ram_dp_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_a, reset_b, clken_a, clken_b, busy_a, busy_b;

  logic        p_cs   [4];
  logic        p_rd   [4];
  logic        p_wr   [4];
  logic [3:0]  p_addr [4];
  logic [3:0]  p_be   [4];
  logic [31:0] p_wd   [4];
  logic [31:0] p_rdata[4];
  logic        p_rv   [4];
  logic        p_wait [4];

  onchip_ram_dp_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus [4] ();

  for (genvar gi = 0; gi < 4; gi++) begin : g_bus
    assign bus[gi].address    = p_addr[gi];
    assign bus[gi].chipselect = p_cs[gi];
    assign bus[gi].read       = p_rd[gi];
    assign bus[gi].write      = p_wr[gi];
    assign bus[gi].byteenable = p_be[gi];
    assign bus[gi].writedata  = p_wd[gi];
    assign p_rdata[gi]        = bus[gi].readdata;
    assign p_rv[gi]           = bus[gi].readdatavalid;
    assign p_wait[gi]         = bus[gi].waitrequest;
  end

  onchip_ram_dp_param #(
    .DATA_WIDTH(32), .DEPTH(16), .ADDR_WIDTH(4),
    .READ_LATENCY(1), .CLEAR_ON_RESET(1), .INIT_FILE("")
  ) u_a (
    .clk(clk), .reset(reset_a), .clken(clken_a),
    .s1(bus[0]), .s2(bus[1]), .busy(busy_a)
  );

  onchip_ram_dp_param #(
    .DATA_WIDTH(32), .DEPTH(12), .ADDR_WIDTH(4),
    .READ_LATENCY(2), .CLEAR_ON_RESET(0), .INIT_FILE("")
  ) u_b (
    .clk(clk), .reset(reset_b), .clken(clken_b),
    .s1(bus[2]), .s2(bus[3]), .busy(busy_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_all();
    for (int i = 0; i < 4; i++) begin
      p_cs[i] = 1'b0; p_rd[i] = 1'b0; p_wr[i] = 1'b0;
      p_addr[i] = '0; p_be[i] = 4'hF; p_wd[i] = '0;
    end
  endtask

  // One transfer on port p; returns 1 ns after the accepting edge.
  task automatic issue(input int p, input bit wr, input bit rd, input logic [3:0] addr,
                       input logic [3:0] be, input logic [31:0] wd);
    p_cs[p] = 1'b1; p_wr[p] = wr; p_rd[p] = rd;
    p_addr[p] = addr; p_be[p] = be; p_wd[p] = wd;
    $display("[%0t] txn port%0d wr=%0b rd=%0b addr=%0d be=%04b wd=0x%08h", $time, p, wr, rd, addr, be, wd);
    @(posedge clk); #1;
    p_cs[p] = 1'b0; p_wr[p] = 1'b0; p_rd[p] = 1'b0;
  endtask

  // Read and count edges until readdatavalid (bounded); lat=-1 on timeout.
  task automatic measure(input int p, input logic [3:0] addr, output int lat, output logic [31:0] data);
    lat  = -1;
    data = '0;
    issue(p, 1'b0, 1'b1, addr, 4'hF, 32'h0);
    for (int k = 1; k <= 8; k++) begin
      if (p_rv[p]) begin
        lat  = k;
        data = p_rdata[p];
        break;
      end
      @(posedge clk); #1;
    end
    $display("[%0t] read port%0d addr=%0d latency=%0d data=0x%08h", $time, p, addr, lat, data);
  endtask

  typedef struct {
    int          port;
    bit          wr;
    bit          rd;
    logic [3:0]  addr;
    logic [3:0]  be;
    logic [31:0] wd;
    bit          exp_valid;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[$];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int          cnt;
    bit          wait_ok;
    int          lat;
    logic [31:0] data;
    logic [31:0] got_q[$];
    bit          seen;
    bit          b2b_en  [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [3:0]  b2b_addr[7] = '{4'd0, 4'd1, 4'd2, 4'd2, 4'd3, 4'd0, 4'd0};
    bit          b2b_ce  [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    // Directed vectors on instance A (latency 1, array zeroed by the clear).
    vecs.push_back('{0, 1'b1, 1'b0, 4'd5,  4'hF,   32'hDEADBEEF, 1'b0, 32'h0});
    vecs.push_back('{0, 1'b0, 1'b1, 4'd5,  4'hF,   32'h0,        1'b1, 32'hDEADBEEF});
    vecs.push_back('{0, 1'b1, 1'b0, 4'd3,  4'b0101, 32'h12345678, 1'b0, 32'h0});
    vecs.push_back('{1, 1'b0, 1'b1, 4'd3,  4'hF,   32'h0,        1'b1, 32'h00340078});
    vecs.push_back('{1, 1'b1, 1'b0, 4'd15, 4'hF,   32'hCAFEF00D, 1'b0, 32'h0});
    vecs.push_back('{0, 1'b0, 1'b1, 4'd15, 4'hF,   32'h0,        1'b1, 32'hCAFEF00D});
    vecs.push_back('{1, 1'b1, 1'b1, 4'd2,  4'hF,   32'h00000077, 1'b0, 32'h0});
    vecs.push_back('{1, 1'b0, 1'b1, 4'd2,  4'hF,   32'h0,        1'b1, 32'h00000077});
    vecs.push_back('{0, 1'b1, 1'b0, 4'd7,  4'hF,   32'h0,        1'b0, 32'h0});
    vecs.push_back('{0, 1'b1, 1'b0, 4'd9,  4'hF,   32'h5,        1'b0, 32'h0});
    for (int a = 0; a < 4; a++) begin
      vecs.push_back('{1, 1'b1, 1'b0, 4'(a), 4'hF, 32'(a), 1'b0, 32'h0});
    end

    idle_all();
    reset_a = 1'b1; reset_b = 1'b1; clken_a = 1'b1; clken_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // ---- reset state ----
    check("rst_busy_a",  32'(busy_a),    32'd1);
    check("rst_wait_a1", 32'(p_wait[0]), 32'd1);
    check("rst_wait_a2", 32'(p_wait[1]), 32'd1);
    check("rst_valid_a", 32'(p_rv[0]),   32'd0);
    check("rst_rdata_a", p_rdata[0],     32'h0);
    check("rst_busy_b",  32'(busy_b),    32'd1);

    // ---- clear sequencer: busy for exactly DEPTH cycles ----
    reset_a = 1'b0; reset_b = 1'b0;
    #1;
    check("run_busy_b", 32'(busy_b), 32'd0);
    cnt = 0; wait_ok = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (!busy_a) break;
      cnt++;
      if (!p_wait[0] || !p_wait[1]) wait_ok = 1'b0;
      @(posedge clk); #1;
    end
    $display("[%0t] clear finished after %0d busy cycles", $time, cnt);
    check("clear_cycles", 32'(cnt), 32'd16);
    check("clear_wait",   32'(wait_ok), 32'd1);
    check("clear_done_wait", 32'(p_wait[0]), 32'd0);
    @(posedge clk); #1;

    for (int a = 0; a < 16; a++) begin
      issue(a % 2, 1'b0, 1'b1, 4'(a), 4'hF, 32'h0);
      check($sformatf("clear_rd%0d_valid", a), 32'(p_rv[a % 2]), 32'd1);
      check($sformatf("clear_rd%0d_data", a), p_rdata[a % 2], 32'h0);
    end

    // ---- table-driven vectors ----
    foreach (vecs[i]) begin
      issue(vecs[i].port, vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].be, vecs[i].wd);
      check($sformatf("vec%0d_valid", i), 32'(p_rv[vecs[i].port]), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d_data", i), p_rdata[vecs[i].port], vecs[i].exp_data);
      end
    end

    // ---- latency 1 + readdata hold ----
    measure(0, 4'd5, lat, data);
    check("lat1_cycles", 32'(lat), 32'd1);
    check("lat1_data", data, 32'hDEADBEEF);
    @(posedge clk); #1;
    check("hold_valid", 32'(p_rv[0]), 32'd0);
    check("hold_data", p_rdata[0], 32'hDEADBEEF);

    // ---- write collision on addr 7 ----
    p_cs[0] = 1'b1; p_wr[0] = 1'b1; p_addr[0] = 4'd7; p_be[0] = 4'b0011; p_wd[0] = 32'h11223344;
    p_cs[1] = 1'b1; p_wr[1] = 1'b1; p_addr[1] = 4'd7; p_be[1] = 4'b1110; p_wd[1] = 32'hAABBCCDD;
    $display("[%0t] txn collision s1/s2 write addr=7", $time);
    @(posedge clk); #1;
    idle_all();
    issue(0, 1'b0, 1'b1, 4'd7, 4'hF, 32'h0);
    check("collision_data", p_rdata[0], 32'hAABB3344);

    // ---- cross-port read-during-write on addr 9 ----
    p_cs[0] = 1'b1; p_wr[0] = 1'b1; p_addr[0] = 4'd9; p_be[0] = 4'hF; p_wd[0] = 32'h6;
    p_cs[1] = 1'b1; p_rd[1] = 1'b1; p_addr[1] = 4'd9;
    $display("[%0t] txn s1 write addr=9 with s2 read addr=9", $time);
    @(posedge clk); #1;
    idle_all();
    check("rdw_valid", 32'(p_rv[1]), 32'd1);
    check("rdw_old",   p_rdata[1],   32'h5);
    check("rdw_wr_novalid", 32'(p_rv[0]), 32'd0);
    issue(1, 1'b0, 1'b1, 4'd9, 4'hF, 32'h0);
    check("rdw_new", p_rdata[1], 32'h6);
    @(posedge clk); #1;

    // ---- back-to-back reads on s2 with a clken stall ----
    for (int c = 0; c < 7; c++) begin
      p_cs[1] = b2b_en[c]; p_rd[1] = b2b_en[c]; p_addr[1] = b2b_addr[c];
      clken_a = b2b_ce[c];
      #1;
      if (!b2b_ce[c]) begin
        check("stall_wait",  32'(p_wait[1]), 32'd1);
        check("stall_valid", 32'(p_rv[1]),   32'd0);
      end
      if (p_rv[1]) begin
        got_q.push_back(p_rdata[1]);
        $display("[%0t] burst valid data=0x%08h", $time, p_rdata[1]);
      end
      @(posedge clk); #1;
    end
    idle_all();
    clken_a = 1'b1;
    check("burst_count", 32'(got_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("burst_data%0d", i), (i < got_q.size()) ? got_q[i] : 32'hFFFFFFFF, 32'(i));
    end

    // ---- instance B: latency 2, out-of-range ----
    issue(2, 1'b1, 1'b0, 4'd5, 4'hF, 32'hDEADBEEF);
    measure(2, 4'd5, lat, data);
    check("lat2_cycles", 32'(lat), 32'd2);
    check("lat2_data", data, 32'hDEADBEEF);
    issue(3, 1'b1, 1'b0, 4'd13, 4'hF, 32'hFFFFFFFF);
    measure(3, 4'd13, lat, data);
    check("oor_cycles", 32'(lat), 32'd2);
    check("oor_data", data, 32'h0);
    @(posedge clk); #1;

    // ---- reset one cycle after a read accept drops it ----
    issue(2, 1'b0, 1'b1, 4'd5, 4'hF, 32'h0);
    reset_b = 1'b1;
    #1;
    check("midrst_busy",  32'(busy_b),    32'd1);
    check("midrst_wait",  32'(p_wait[2]), 32'd1);
    check("midrst_valid", 32'(p_rv[2]),   32'd0);
    @(posedge clk); #1;
    reset_b = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (p_rv[2]) seen = 1'b1;
      @(posedge clk); #1;
    end
    check("midrst_dropped", 32'(seen), 32'd0);
    check("midrst_run", 32'(busy_b), 32'd0);
    measure(2, 4'd5, lat, data);
    check("preserve_data", data, 32'hDEADBEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
